booth_mul_seq: RTL and testbench
================================

# booth_mul_seq

Parametrised sequential multiplier producing a 2·WIDTH-bit product from two WIDTH-bit operands, one partial-product step per clock. It selects per operation between unsigned shift-add and signed radix-2 Booth recoding. A start/busy/done handshake replaces free-running operation. It sits in the arithmetic datapath as the shared multi-cycle multiply resource for the 4-bit unsigned multiplier's wider and signed use cases.

## Interface
- WIDTH, 8, operand width; legal range ≥ 2; product is 2·WIDTH bits
- clk  in  1  clock; all state changes on rising edge
- n_rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- signed_mode  in  1  1 = two's-complement operands (Booth), 0 = unsigned; sampled with start
- multiplicand  in  WIDTH  M; sampled with start
- multiplier  in  WIDTH  Q; sampled with start
- busy  out  1  high while iterating (state RUN)
- done  out  1  single-cycle pulse, product valid
- product  out  2·WIDTH  result; held until the next completion

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, busy=0, done=0, product=0, count=0.
- IDLE/DONE with start=1: load A=0 (WIDTH+1 bits), Q=multiplier, M=multiplicand, q_1=0, mode=signed_mode, count=WIDTH; go to RUN.
- DONE with start=0: go to IDLE.
- RUN iteration, unsigned: if Q[0], A = A + zext(M). Then logical right shift {A,Q} with 0 into the MSB.
- RUN iteration, signed: on {Q[0],q_1}, 01 gives A = A + sext(M), 10 gives A = A − sext(M), 00/11 leave A. Then arithmetic right shift {A,Q,q_1}, replicating A[WIDTH].
- A is WIDTH+1 bits, so no intermediate overflow in either mode, including M = −2^(WIDTH−1).
- count decrements each iteration. On the iteration where count reaches 0: product ← {A[WIDTH−1:0],Q} (post-shift), state → DONE.
- start during RUN is ignored; the operation in flight is unaffected and no request is queued.
- Operand and mode inputs are don't-care except on the start-accept edge.

## Timing
- start accepted at edge N. busy=1 from after edge N until after edge N+WIDTH.
- Iterations occur on edges N+1 … N+WIDTH.
- product updates and done=1 after edge N+WIDTH. done falls after edge N+WIDTH+1.
- Latency is WIDTH cycles from the accept edge to done.
- Back-to-back: start held high while done=1 is accepted on edge N+WIDTH+1, giving a throughput of one result per WIDTH+1 cycles.
- busy and done are registered; they are never both high.
- n_rst asserted mid-operation: immediate return to reset values. The partial result is discarded and no done is issued.

## Configuration
- BOOTH_MUL_ACC_EN defined: adds input addend (2·WIDTH bits), sampled with start. The final product = {A,Q} + addend mod 2^(2·WIDTH), applied in the completion cycle with no added latency. The addend's bits are used unchanged in both modes; two's-complement wrap makes this correct for signed.
- Undefined: no addend port; product = {A,Q}.

## Structure
- booth_mul_pkg: state_t enum (IDLE, RUN, DONE) and the count-width helper constant.
- Sub-module booth_step: combinational single iteration. Inputs A, Q, q_1, M, mode; outputs next A, Q, q_1. Instanced once in booth_mul_seq, which holds the FSM, counter and registers.

## Test plan
- WIDTH=8, unsigned 13×11 → product=0x008F, done exactly 8 cycles after the accept edge, busy high for 8 cycles.
- WIDTH=8, unsigned 255×255 → 0xFE01; signed −3×5 → 0xFFF1; signed −128×−128 → 0x4000.
- Re-pulse start with different operands while busy → ignored; original 13×11 result 0x008F delivered on schedule.
- Hold start high across done with new operands 7×6 (unsigned) → second done 9 cycles after the first, product=0x002A.
- Assert n_rst 4 cycles into an operation → busy=0, done=0, product=0 immediately; no done follows.
- BOOTH_MUL_ACC_EN defined, unsigned 6×7 with addend=100 → 0x008E; signed −1×1 with addend=1 → 0x0000.

Source files
------------

// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: shared FSM state type and counter sizing for the sequential Booth multiplier.
package booth_mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Counter must hold WIDTH itself, not just WIDTH-1.
    function automatic int count_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_mul_if.sv
// booth_mul_if: start/busy/done request bus of the sequential multiplier.
// BOOTH_MUL_ACC_EN adds the addend operand.
interface booth_mul_if #(parameter int WIDTH = 8);

    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
`ifdef BOOTH_MUL_ACC_EN
    logic [2*WIDTH-1:0]     addend;
`endif

    modport master (
`ifdef BOOTH_MUL_ACC_EN
        output addend,
`endif
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
`ifdef BOOTH_MUL_ACC_EN
        input  addend,
`endif
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );

endinterface

// File: rtl/booth_step.sv
// booth_step: one combinational iteration, unsigned shift-add or signed radix-2 Booth.
module booth_step #(parameter int WIDTH = 8) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH-1:0] m,
    input  logic             mode,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q1_next
);

    logic [WIDTH:0] op;
    logic [WIDTH:0] a_sum;
    logic           add;
    logic           sub;

    // The extra A bit absorbs the carry (unsigned) or the sign of -M for M = -2^(WIDTH-1).
    always_comb begin
        op      = mode ? {m[WIDTH-1], m} : {1'b0, m};
        add     = mode ? (q[0] ^ q_1) : q[0];
        sub     = mode & q[0] & ~q_1;
        a_sum   = add ? (sub ? a - op : a + op) : a;
        a_next  = {mode & a_sum[WIDTH], a_sum[WIDTH:1]};
        q_next  = {a_sum[0], q[WIDTH-1:1]};
        q1_next = q[0];
    end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential WIDTH x WIDTH multiplier, one partial product per clock.
// BOOTH_MUL_ACC_EN adds a 2*WIDTH addend folded in on the completion cycle.
module booth_mul_seq
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    booth_mul_if.slave  bus
);

    localparam int CW = count_bits(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH:0]     a;
    logic [WIDTH:0]     a_next;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   q_next;
    logic [WIDTH-1:0]   m;
    logic               q_1;
    logic               q1_next;
    logic               mode;
    logic [CW-1:0]      count;
    logic               accept;
    logic               last;
    logic [2*WIDTH-1:0] result;
`ifdef BOOTH_MUL_ACC_EN
    logic [2*WIDTH-1:0] addend;
`endif

    assign accept = (state != RUN) && bus.start;
    assign last   = (state == RUN) && (count == CW'(1));

`ifdef BOOTH_MUL_ACC_EN
    assign result = {a_next[WIDTH-1:0], q_next} + addend;
`else
    assign result = {a_next[WIDTH-1:0], q_next};
`endif

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a       (a),
        .q       (q),
        .q_1     (q_1),
        .m       (m),
        .mode    (mode),
        .a_next  (a_next),
        .q_next  (q_next),
        .q1_next (q1_next)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept)
            state_next = RUN;
        else if (state == DONE)
            state_next = IDLE;
        else if (last)
            state_next = DONE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= '0;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            q_1         <= 1'b0;
            mode        <= 1'b0;
            count       <= '0;
`ifdef BOOTH_MUL_ACC_EN
            addend      <= '0;
`endif
        end else begin
            bus.busy <= state_next == RUN;
            bus.done <= state_next == DONE;
            if (accept) begin
                a     <= '0;
                q     <= bus.multiplier;
                m     <= bus.multiplicand;
                q_1   <= 1'b0;
                mode  <= bus.signed_mode;
                count <= CW'(WIDTH);
`ifdef BOOTH_MUL_ACC_EN
                addend <= bus.addend;
`endif
            end else if (state == RUN) begin
                a     <= a_next;
                q     <= q_next;
                q_1   <= q1_next;
                count <= count - CW'(1);
                if (last)
                    bus.product <= result;
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: randomized self-checking bench against an arithmetic product model.
module tb_booth_mul_seq;

    localparam int W = 8;
    localparam int P = 2 * W;

    logic clk = 1'b0;
    logic n_rst;
    int   tests = 0;
    int   fails = 0;
    logic [P-1:0] cur_ad = '0;

    always #5 clk = ~clk;

    booth_mul_if #(.WIDTH(W)) bus ();

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    function automatic logic [P-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q,
                                           input logic sm, input logic [P-1:0] ad);
        longint p;
        if (sm)
            p = longint'($signed(m)) * longint'($signed(q));
        else
            p = longint'(m) * longint'(q);
        p = p + longint'(ad);
        return p[P-1:0];
    endfunction

    task automatic drive(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic sm, input logic [P-1:0] ad);
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.signed_mode  = sm;
        cur_ad           = ad;
`ifdef BOOTH_MUL_ACC_EN
        bus.addend       = ad;
`endif
        bus.start        = 1'b1;
    endtask

    // Accept on the next edge, then count edges until done (bounded).
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic sm,
                          input logic [P-1:0] ad, output int lat, output int busy_n,
                          output logic [P-1:0] prod);
        drive(m, q, sm, ad);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        prod = bus.product;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
`ifdef BOOTH_MUL_ACC_EN
        bus.addend = '0;
`endif
        #2;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", bus.done); end
        tests++; if (bus.product !== '0) begin fails++; $display("FAIL reset_product got=%h want=0", bus.product); end
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        int lat, bn;
        logic [P-1:0] pr;
        run_op(8'd13, 8'd11, 1'b0, '0, lat, bn, pr);
        tests++; if (pr !== 16'h008F) begin fails++; $display("FAIL u13x11 got=%h want=008f", pr); end
        tests++; if (lat !== W) begin fails++; $display("FAIL u13x11_latency got=%0d want=%0d", lat, W); end
        tests++; if (bn !== W) begin fails++; $display("FAIL u13x11_busy_cycles got=%0d want=%0d", bn, W); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL busy_with_done got=%b want=0", bus.busy); end
        @(posedge clk); #1;
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL done_pulse got=%b want=0", bus.done); end
        run_op(8'd255, 8'd255, 1'b0, '0, lat, bn, pr);
        tests++; if (pr !== 16'hFE01) begin fails++; $display("FAIL u255x255 got=%h want=fe01", pr); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed;
        int lat, bn;
        logic [P-1:0] pr;
        run_op(8'hFD, 8'd5, 1'b1, '0, lat, bn, pr);
        tests++; if (pr !== 16'hFFF1) begin fails++; $display("FAIL s_m3x5 got=%h want=fff1", pr); end
        tests++; if (lat !== W) begin fails++; $display("FAIL s_m3x5_latency got=%0d want=%0d", lat, W); end
        @(posedge clk); #1;
        run_op(8'h80, 8'h80, 1'b1, '0, lat, bn, pr);
        tests++; if (pr !== 16'h4000) begin fails++; $display("FAIL s_m128xm128 got=%h want=4000", pr); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int lat, bn;
        logic [P-1:0] pr, exp_p, ad;
        logic [W-1:0] m, q;
        logic sm;
        for (int i = 0; i < 24; i++) begin
            m = W'($urandom);
            q = W'($urandom);
            sm = 1'($urandom);
`ifdef BOOTH_MUL_ACC_EN
            ad = P'($urandom);
`else
            ad = '0;
`endif
            run_op(m, q, sm, ad, lat, bn, pr);
            exp_p = model(m, q, sm, cur_ad);
            tests++;
            if (pr !== exp_p || lat !== W) begin
                fails++;
                $display("FAIL random[%0d] m=%h q=%h sm=%b got=%h lat=%0d want=%h lat=%0d",
                         i, m, q, sm, pr, lat, exp_p, W);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_ignore;
        int lat, extra;
        drive(8'd13, 8'd11, 1'b0, '0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drive(8'd200, 8'd199, 1'b1, '0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.multiplicand = 8'd1;
        lat = 4;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++; if (bus.product !== 16'h008F) begin fails++; $display("FAIL ignore_product got=%h want=008f", bus.product); end
        tests++; if (lat !== W) begin fails++; $display("FAIL ignore_latency got=%0d want=%0d", lat, W); end
        extra = 0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL ignore_no_queue got=%0d active cycles want=0", extra); end
    endtask

    task automatic test_back_to_back;
        int lat, bn, gap;
        logic [P-1:0] pr;
        drive(8'd13, 8'd11, 1'b0, '0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++; if (bus.product !== 16'h008F) begin fails++; $display("FAIL b2b_first got=%h want=008f", bus.product); end
        drive(8'd7, 8'd6, 1'b0, '0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        gap = 1;
        tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_accept done=%b busy=%b want done=0 busy=1", bus.done, bus.busy); end
        while (!bus.done && gap < 40) begin
            @(posedge clk); #1;
            gap++;
        end
        tests++; if (gap !== W + 1) begin fails++; $display("FAIL b2b_gap got=%0d want=%0d", gap, W + 1); end
        tests++; if (bus.product !== 16'h002A) begin fails++; $display("FAIL b2b_second got=%h want=002a", bus.product); end
        @(posedge clk); #1;
        bn = 0;
    endtask

    task automatic test_async_reset;
        int seen;
        drive(8'd100, 8'd3, 1'b0, '0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL arst_busy got=%b want=0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL arst_done got=%b want=0", bus.done); end
        tests++; if (bus.product !== '0) begin fails++; $display("FAIL arst_product got=%h want=0", bus.product); end
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL arst_no_done got=%0d active cycles want=0", seen); end
    endtask

`ifdef BOOTH_MUL_ACC_EN
    task automatic test_acc;
        int lat, bn;
        logic [P-1:0] pr;
        run_op(8'd6, 8'd7, 1'b0, 16'd100, lat, bn, pr);
        tests++; if (pr !== 16'h008E) begin fails++; $display("FAIL acc_6x7p100 got=%h want=008e", pr); end
        tests++; if (lat !== W) begin fails++; $display("FAIL acc_latency got=%0d want=%0d", lat, W); end
        @(posedge clk); #1;
        run_op(8'hFF, 8'd1, 1'b1, 16'd1, lat, bn, pr);
        tests++; if (pr !== 16'h0000) begin fails++; $display("FAIL acc_m1x1p1 got=%h want=0000", pr); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
`ifdef BOOTH_MUL_ACC_EN
        test_acc();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
